// File: rtl/dp_stream_collector_if.sv
// AXI-Stream style output bus of dp_stream_collector.
// Handshake: a beat transfers on every clock edge where m_axis_tvalid and
// m_axis_tready are both high; while tvalid is high and tready is low the
// master holds m_axis_tdata and m_axis_tlast stable.
interface dp_stream_collector_if #(
    parameter int PHIT_SIZE = 512
);
    logic [PHIT_SIZE-1:0] m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tlast;
    logic                 m_axis_tready;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/dp_stream_collector.sv
// dp_stream_collector: captures phits leaving the fixed-latency SIMD PE data
// path, buffers them in a circular FIFO and drains them on an AXI-Stream style
// master bus. Issue credits cover both buffered and in-flight phits, so a
// well-behaved upstream can never make the stall-free pipeline overflow.
// Optional statistics counters: define DP_COLLECTOR_STATS_EN.
module dp_stream_collector #(
    parameter int PHIT_SIZE  = 512,
    parameter int DP_LATENCY = 6,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          issue_valid,
    input  logic                          issue_last,
    output logic                          issue_ready,
    input  logic [PHIT_SIZE-1:0]          dp_stream_out,
    dp_stream_collector_if.master         m_axis,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow_err
`ifdef DP_COLLECTOR_STATS_EN
    ,
    output logic [31:0]                   stat_phits_out,
    output logic [31:0]                   stat_stall_cycles,
    output logic [15:0]                   stat_msgs_out
`endif
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // {valid, last} delay line mirroring the data path pipeline
    logic [DP_LATENCY-1:0] dl_valid, dl_last;
    logic [DP_LATENCY-1:0] dl_valid_next, dl_last_next;

    logic [PHIT_SIZE-1:0]  mem_data [FIFO_DEPTH];
    logic                  mem_last [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count, count_next;

    logic                  capture, full, push, pop, drop, tvalid;
    logic [15:0]           in_flight_next, occupancy_next;

    assign capture = dl_valid[DP_LATENCY-1];
    assign full    = (count == CW'(FIFO_DEPTH));
    assign tvalid  = (count != '0);
    assign pop     = tvalid && m_axis.m_axis_tready;
    // A capture into a full FIFO still fits when a pop frees the head slot.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    assign m_axis.m_axis_tvalid = tvalid;
    assign m_axis.m_axis_tdata  = tvalid ? mem_data[rd_ptr] : '0;
    assign m_axis.m_axis_tlast  = tvalid ? mem_last[rd_ptr] : 1'b0;
    assign fifo_count           = count;

    // Next contents of the delay line: new issue enters stage 0, others shift
    always_comb begin
        dl_valid_next    = '0;
        dl_last_next     = '0;
        dl_valid_next[0] = issue_valid;
        dl_last_next[0]  = issue_last;
        for (int i = 1; i < DP_LATENCY; i++) begin
            dl_valid_next[i] = dl_valid[i-1];
            dl_last_next[i]  = dl_last[i-1];
        end
    end

    // Next occupancy: buffered phits plus phits still inside the pipeline
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
        in_flight_next = '0;
        for (int i = 0; i < DP_LATENCY; i++) begin
            in_flight_next = in_flight_next + 16'(dl_valid_next[i]);
        end
        occupancy_next = in_flight_next + 16'(count_next);
    end

    // Delay line register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dl_valid <= '0;
            dl_last  <= '0;
        end else begin
            dl_valid <= dl_valid_next;
            dl_last  <= dl_last_next;
        end
    end

    // FIFO storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_data[wr_ptr] <= dp_stream_out;
            mem_last[wr_ptr] <= dl_last[DP_LATENCY-1];
        end
    end

    // FIFO pointers, occupancy, sticky overflow and registered credit flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
            issue_ready  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            if (drop) begin
                overflow_err <= 1'b1;
            end
            issue_ready <= (occupancy_next < 16'(FIFO_DEPTH));
        end
    end

`ifdef DP_COLLECTOR_STATS_EN
    // Saturating statistics counters for pops, messages and stalled cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_phits_out    <= '0;
            stat_stall_cycles <= '0;
            stat_msgs_out     <= '0;
        end else begin
            if (pop && (stat_phits_out != '1)) begin
                stat_phits_out <= stat_phits_out + 32'd1;
            end
            if (pop && m_axis.m_axis_tlast && (stat_msgs_out != '1)) begin
                stat_msgs_out <= stat_msgs_out + 16'd1;
            end
            if (tvalid && !m_axis.m_axis_tready && (stat_stall_cycles != '1)) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dp_stream_collector.sv
// Self-checking bench for dp_stream_collector: directed scenarios plus a
// randomized phase, all compared every cycle against a queue-based model.
module tb_dp_stream_collector;
    localparam int PHIT_SIZE  = 512;
    localparam int DP_LATENCY = 6;
    localparam int FIFO_DEPTH = 16;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    typedef logic [PHIT_SIZE-1:0] word_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_valid;
    logic          issue_last;
    logic          issue_ready;
    word_t         dp_stream_out;
    logic [CW-1:0] fifo_count;
    logic          overflow_err;
`ifdef DP_COLLECTOR_STATS_EN
    logic [31:0]   stat_phits_out;
    logic [31:0]   stat_stall_cycles;
    logic [15:0]   stat_msgs_out;
`endif

    dp_stream_collector_if #(.PHIT_SIZE(PHIT_SIZE)) m_axis ();

    dp_stream_collector #(
        .PHIT_SIZE (PHIT_SIZE),
        .DP_LATENCY(DP_LATENCY),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_last   (issue_last),
        .issue_ready  (issue_ready),
        .dp_stream_out(dp_stream_out),
        .m_axis       (m_axis.master),
        .fifo_count   (fifo_count),
        .overflow_err (overflow_err)
`ifdef DP_COLLECTOR_STATS_EN
        ,
        .stat_phits_out   (stat_phits_out),
        .stat_stall_cycles(stat_stall_cycles),
        .stat_msgs_out    (stat_msgs_out)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic word_t rand_phit();
        word_t w;
        for (int i = 0; i < PHIT_SIZE / 32; i++) begin
            w[i*32 +: 32] = $urandom;
        end
        return w;
    endfunction

    // Reference model: issues wait DP_LATENCY cycles, then whatever is on
    // dp_stream_out is captured into a plain queue FIFO of {last, data}.
    logic [PHIT_SIZE:0] exp_q[$];
    int  pend_cyc[$];
    bit  pend_last[$];
    int  cyc         = 0;
    bit  model_ready = 1'b1;
    bit  model_ovf   = 1'b0;
    bit  cmp_en      = 1'b0;

    always @(posedge clk) begin : model
        bit popm, cap, was_full;
        if (!rst_n) begin
            exp_q.delete();
            pend_cyc.delete();
            pend_last.delete();
            model_ready = 1'b1;
            model_ovf   = 1'b0;
        end else begin
            popm     = (exp_q.size() != 0) && m_axis.m_axis_tready;
            was_full = (exp_q.size() == FIFO_DEPTH);
            cap      = (pend_cyc.size() != 0) && (pend_cyc[0] + DP_LATENCY == cyc);
            if (popm) begin
                void'(exp_q.pop_front());
            end
            if (cap) begin
                if (was_full && !popm) begin
                    model_ovf = 1'b1;
                end else begin
                    exp_q.push_back({pend_last[0], dp_stream_out});
                end
                void'(pend_cyc.pop_front());
                void'(pend_last.pop_front());
            end
            if (issue_valid) begin
                pend_cyc.push_back(cyc);
                pend_last.push_back(issue_last);
            end
            model_ready = (exp_q.size() + pend_cyc.size()) < FIFO_DEPTH;
        end
        cyc++;
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("tvalid", word_t'(m_axis.m_axis_tvalid), word_t'(exp_q.size() != 0));
            chk("fifo_count", word_t'(fifo_count), word_t'(exp_q.size()));
            chk("issue_ready", word_t'(issue_ready), word_t'(model_ready));
            chk("overflow_err", word_t'(overflow_err), word_t'(model_ovf));
            if (exp_q.size() != 0) begin
                chk("tdata", m_axis.m_axis_tdata, exp_q[0][PHIT_SIZE-1:0]);
                chk("tlast", word_t'(m_axis.m_axis_tlast), word_t'(exp_q[0][PHIT_SIZE]));
            end
        end
    end

    // Driver: apply inputs for one cycle, return just after the next edge
    task automatic drive(input bit iv, input bit il, input bit tr, input word_t data);
        issue_valid           = iv;
        issue_last            = il;
        m_axis.m_axis_tready  = tr;
        dp_stream_out         = data;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit tr);
        repeat (n) drive(1'b0, 1'b0, tr, rand_phit());
    endtask

    task automatic fill_full();
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            drive(1'b1, (i % 4) == 3, 1'b0, rand_phit());
        end
        idle(DP_LATENCY, 1'b0);
    endtask

    word_t a5;

    initial begin
        rst_n                = 1'b0;
        issue_valid          = 1'b0;
        issue_last           = 1'b0;
        m_axis.m_axis_tready = 1'b0;
        dp_stream_out        = '0;
        a5                   = {64{8'hA5}};
        @(posedge clk);
        #1;
        idle(2, 1'b0);
        rst_n = 1'b1;

        // Reset values
        chk("rst_tvalid", word_t'(m_axis.m_axis_tvalid), '0);
        chk("rst_tlast", word_t'(m_axis.m_axis_tlast), '0);
        chk("rst_tdata", m_axis.m_axis_tdata, '0);
        chk("rst_fifo_count", word_t'(fifo_count), '0);
        chk("rst_overflow", word_t'(overflow_err), '0);
        chk("rst_issue_ready", word_t'(issue_ready), word_t'(1));
        cmp_en = 1'b1;

        // Single phit: issue at cycle 0, data at cycle 6, visible at cycle 7
        drive(1'b1, 1'b1, 1'b1, rand_phit());
        idle(DP_LATENCY - 1, 1'b1);
        chk("single_not_early", word_t'(m_axis.m_axis_tvalid), '0);
        drive(1'b0, 1'b0, 1'b1, a5);
        chk("single_tvalid", word_t'(m_axis.m_axis_tvalid), word_t'(1));
        chk("single_tdata", m_axis.m_axis_tdata, a5);
        chk("single_tlast", word_t'(m_axis.m_axis_tlast), word_t'(1));
        idle(1, 1'b1);
        chk("single_drained", word_t'(fifo_count), '0);

        // Back-to-back burst of 16 with backpressure
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            chk("burst_ready", word_t'(issue_ready), word_t'(1));
            drive(1'b1, i == FIFO_DEPTH - 1, 1'b0, rand_phit());
        end
        chk("burst_ready_low", word_t'(issue_ready), '0);
        idle(DP_LATENCY, 1'b0);
        chk("burst_full", word_t'(fifo_count), word_t'(FIFO_DEPTH));
        chk("burst_no_ovf", word_t'(overflow_err), '0);

        // Release backpressure: one phit per cycle, tlast only on the 16th
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            chk("drain_valid", word_t'(m_axis.m_axis_tvalid), word_t'(1));
            chk("drain_last", word_t'(m_axis.m_axis_tlast), word_t'(i == FIFO_DEPTH - 1));
            drive(1'b0, 1'b0, 1'b1, rand_phit());
        end
        chk("drain_empty", word_t'(fifo_count), '0);

        // Full FIFO with simultaneous capture and pop across the pointer wrap
        fill_full();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, rand_phit());
        end
        idle(DP_LATENCY - 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("pushpop_count", word_t'(fifo_count), word_t'(FIFO_DEPTH));
            drive(1'b0, 1'b0, 1'b1, rand_phit());
        end
        chk("pushpop_count_after", word_t'(fifo_count), word_t'(FIFO_DEPTH));
        chk("pushpop_no_ovf", word_t'(overflow_err), '0);
        idle(FIFO_DEPTH + 2, 1'b1);
        chk("pushpop_drained", word_t'(fifo_count), '0);

        // Protocol violation into a full FIFO with no pop
        fill_full();
        drive(1'b1, 1'b0, 1'b0, rand_phit());
        idle(DP_LATENCY - 1, 1'b0);
        chk("viol_before_capture", word_t'(overflow_err), '0);
        idle(1, 1'b0);
        chk("viol_ovf_set", word_t'(overflow_err), word_t'(1));
        chk("viol_count", word_t'(fifo_count), word_t'(FIFO_DEPTH));
        idle(4, 1'b1);
        chk("viol_ovf_sticky", word_t'(overflow_err), word_t'(1));

        // Reset mid-stream: 5 buffered, 3 in flight
        rst_n = 1'b0;
        idle(1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, rand_phit());
        end
        idle(DP_LATENCY, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, rand_phit());
        end
        chk("pre_reset_count", word_t'(fifo_count), word_t'(5));
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, rand_phit());
        chk("midrst_tvalid", word_t'(m_axis.m_axis_tvalid), '0);
        chk("midrst_count", word_t'(fifo_count), '0);
        chk("midrst_ready", word_t'(issue_ready), word_t'(1));
        chk("midrst_ovf", word_t'(overflow_err), '0);
        rst_n = 1'b1;
        for (int i = 0; i < DP_LATENCY + 4; i++) begin
            chk("postrst_no_stale", word_t'(m_axis.m_axis_tvalid), '0);
            drive(1'b0, 1'b0, 1'b1, rand_phit());
        end

        // Randomized traffic obeying the credit protocol
        for (int n = 0; n < 600; n++) begin
            drive(model_ready && ($urandom_range(0, 9) < 7),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) < 6,
                  rand_phit());
        end
        idle(DP_LATENCY + FIFO_DEPTH + 4, 1'b1);
        chk("final_empty", word_t'(fifo_count), '0);
        chk("final_no_ovf", word_t'(overflow_err), '0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
